// File: rtl/alsu_result_checker_if.sv
// Sample bus (DUT vs golden outputs) plus the failure-record valid/ready channel.
// Latency: none, wires only.
// Backpressure: err_ready from the reader stalls the record channel; the sample side has no backpressure.
interface alsu_result_checker_if;
  logic              sample_valid;
  logic signed [5:0] out;
  logic signed [5:0] out_ex;
  logic [15:0]       leds;
  logic [15:0]       leds_ex;
  logic              err_valid;
  logic              err_ready;
  logic [43:0]       err_data;

  // Stimulus/reader side: drives samples and accepts failure records.
  modport master (
    output sample_valid, out, out_ex, leds, leds_ex, err_ready,
    input  err_valid, err_data
  );

  // Checker side: consumes samples and offers failure records.
  modport slave (
    input  sample_valid, out, out_ex, leds, leds_ex, err_ready,
    output err_valid, err_data
  );
endinterface

// File: rtl/alsu_result_checker.sv
// Compares ALSU DUT outputs against golden outputs LATENCY cycles after stimulus; counts pass/fail/drop, queues failures.
// Latency: sample_valid at edge t -> compare at edge t+LATENCY -> counters/err_valid updated after edge t+LATENCY+1.
// Backpressure: err_ready stalls the failure FIFO; a failure arriving while full (and not popped) is dropped and counted.
// Optional: define ALSU_CHK_LEDS_EN to also compare leds against leds_ex and record their XOR.
module alsu_result_checker #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  alsu_result_checker_if.slave bus,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = 44;

  logic [LATENCY-1:0] dly;
  logic               cmp_en;
  logic [15:0]        stamp;
  logic [15:0]        leds_diff;
  logic               mismatch;

  // Registered compare result: one cycle between the compare edge and the counter/FIFO update.
  logic               res_vld;
  logic               res_fail;
  logic [REC_W-1:0]   res_rec;

  logic [REC_W-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;

  assign cmp_en = dly[LATENCY-1];

`ifdef ALSU_CHK_LEDS_EN
  assign leds_diff = bus.leds ^ bus.leds_ex;
  assign mismatch  = (bus.out != bus.out_ex) || (leds_diff != 16'h0000);
`else
  assign leds_diff = 16'h0000;
  assign mismatch  = (bus.out != bus.out_ex);
  wire unused_leds = ^{bus.leds, bus.leds_ex};
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Shift sample_valid through the alignment delay line; its last stage marks the compare cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly <= '0;
    end else if (clear) begin
      dly <= '0;
    end else begin
      dly <= LATENCY'({dly, bus.sample_valid});
    end
  end

  // Free-running timestamp, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp <= 16'h0000;
    end else if (clear) begin
      stamp <= 16'h0000;
    end else begin
      stamp <= stamp + 16'd1;
    end
  end

  // Capture the compare outcome and the failure record on the compare edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld  <= 1'b0;
      res_fail <= 1'b0;
      res_rec  <= '0;
    end else if (clear) begin
      res_vld  <= 1'b0;
      res_fail <= 1'b0;
      res_rec  <= '0;
    end else begin
      res_vld  <= cmp_en;
      res_fail <= cmp_en & mismatch;
      if (cmp_en) begin
        res_rec <= {stamp, bus.out, bus.out_ex, leds_diff};
      end
    end
  end

  // A pop frees a slot on the same edge, so a full FIFO can still accept a push when read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = bus.err_valid && bus.err_ready;
  assign push       = res_fail && (!fifo_full || pop);
  assign drop       = res_fail && fifo_full && !pop;

  // Failure-record storage; contents are only observable through the valid-gated read port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= res_rec;
    end
  end

  // FIFO pointers with an extra wrap bit to distinguish full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // First-word-fall-through read port; data forced to zero while empty.
  assign bus.err_valid = !fifo_empty;
  assign bus.err_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Saturating pass/fail/drop counters, updated one cycle after the compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pass_cnt <= sat_inc(pass_cnt, res_vld & ~res_fail);
      fail_cnt <= sat_inc(fail_cnt, res_fail);
      drop_cnt <= sat_inc(drop_cnt, drop);
    end
  end

endmodule

// File: tb/tb_alsu_result_checker.sv
// Bench for alsu_result_checker: directed table, hand-written corner sequences, random traffic vs a queue-based model.
// Latency: model schedules compares LATENCY edges after a sample and effects one edge later.
// Backpressure: err_ready is driven directly, including long stalls to force drops.
module tb_alsu_result_checker;
  localparam int L    = 2;
  localparam int D    = 8;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;
`ifdef ALSU_CHK_LEDS_EN
  localparam bit LEDS_ON = 1'b1;
`else
  localparam bit LEDS_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          clear;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [CW-1:0] drop_cnt;

  alsu_result_checker_if bus ();

  alsu_result_checker #(.LATENCY(L), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit ev_seen;

  // Reference model state: queues of in-flight sample edges and of failure records.
  int          e = 0;
  int          inflight[$];
  logic [43:0] mq[$];
  int          m_pass, m_fail, m_drop;
  logic [15:0] m_stamp;
  bit          eff_vld, eff_mis;
  logic [43:0] eff_rec;

  typedef struct {
    logic [5:0]  o;
    logic [5:0]  oe;
    logic [15:0] l;
    logic [15:0] le;
    bit          mis;
    logic [15:0] low;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    mq.delete();
    m_pass = 0; m_fail = 0; m_drop = 0;
    m_stamp = 16'h0000;
    eff_vld = 1'b0; eff_mis = 1'b0; eff_rec = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented before that edge.
  task automatic model_edge();
    bit          popped;
    int          sz0;
    logic [15:0] ldiff;
    if (!rst || clear) begin
      model_reset();
    end else begin
      sz0    = mq.size();
      popped = (sz0 != 0) && bus.err_ready;
      if (popped) void'(mq.pop_front());
      if (eff_vld) begin
        if (eff_mis) begin
          if (m_fail < MAXC) m_fail++;
          if (sz0 < D || popped) mq.push_back(eff_rec);
          else if (m_drop < MAXC) m_drop++;
        end else if (m_pass < MAXC) begin
          m_pass++;
        end
      end
      eff_vld = 1'b0;
      if (inflight.size() != 0 && inflight[0] == e - L) begin
        void'(inflight.pop_front());
        ldiff   = LEDS_ON ? (bus.leds ^ bus.leds_ex) : 16'h0000;
        eff_mis = (bus.out != bus.out_ex) || (ldiff != 16'h0000);
        eff_rec = {m_stamp, bus.out, bus.out_ex, ldiff};
        eff_vld = 1'b1;
      end
      if (bus.sample_valid) inflight.push_back(e);
      m_stamp = m_stamp + 16'd1;
    end
    e++;
  endtask

  task automatic auto_check();
    logic        exp_v;
    logic [43:0] exp_d;
    exp_v = (mq.size() != 0);
    exp_d = exp_v ? mq[0] : 44'h0;
    check("err_valid", 64'(bus.err_valid), 64'(exp_v));
    check("err_data", 64'(bus.err_data), 64'(exp_d));
    check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
    check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    ev_seen |= bus.err_valid;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    auto_check();
  endtask

  task automatic clear_tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int          n;
    logic [CW-1:0] p0, f0;

    tbl[0] = '{6'd5,  6'd5,  16'h0000, 16'h0000, 1'b0,    16'h0000};
    tbl[1] = '{6'd3,  6'h3D, 16'h0000, 16'h0000, 1'b1,    16'h0000};
    tbl[2] = '{6'd5,  6'd5,  16'h00F0, 16'h00FF, LEDS_ON, LEDS_ON ? 16'h000F : 16'h0000};
    tbl[3] = '{6'h20, 6'h1F, 16'hAAAA, 16'hAAAA, 1'b1,    16'h0000};
    tbl[4] = '{6'h00, 6'h00, 16'hFFFF, 16'h0000, LEDS_ON, LEDS_ON ? 16'hFFFF : 16'h0000};
    tbl[5] = '{6'h3F, 6'h3F, 16'h1234, 16'h1234, 1'b0,    16'h0000};

    rst = 1'b0; clear = 1'b0;
    bus.sample_valid = 1'b0; bus.out = '0; bus.out_ex = '0;
    bus.leds = '0; bus.leds_ex = '0; bus.err_ready = 1'b0;
    model_reset();
    repeat (2) tick();
    check("rst_err_valid", 64'(bus.err_valid), 64'd0);
    check("rst_err_data", 64'(bus.err_data), 64'd0);
    check("rst_pass", 64'(pass_cnt), 64'd0);
    rst = 1'b1;

    // Ten matching samples: all pass, nothing queued.
    ev_seen = 1'b0;
    bus.out = 6'd5; bus.out_ex = 6'd5;
    bus.sample_valid = 1'b1;
    repeat (10) tick();
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    check("t1_pass", 64'(pass_cnt), 64'd10);
    check("t1_fail", 64'(fail_cnt), 64'd0);
    check("t1_no_err_valid", 64'(ev_seen), 64'd0);

    // Single mismatch compared while stamp = 0x0012.
    clear_tick();
    bus.out = 6'd3; bus.out_ex = 6'h3D;
    repeat (16) tick();
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (2) tick();
    check("t2_valid_at_compare", 64'(bus.err_valid), 64'd0);
    tick();
    check("t2_valid_after", 64'(bus.err_valid), 64'd1);
    check("t2_err_data", 64'(bus.err_data), 64'h00120FD0000);
    check("t2_fail", 64'(fail_cnt), 64'd1);
    bus.err_ready = 1'b1;
    repeat (2) tick();

    // Directed vector table, one sample per entry.
    for (int k = 0; k < 6; k++) begin
      bus.out = tbl[k].o; bus.out_ex = tbl[k].oe;
      bus.leds = tbl[k].l; bus.leds_ex = tbl[k].le;
      p0 = pass_cnt; f0 = fail_cnt;
      bus.sample_valid = 1'b1;
      tick();
      bus.sample_valid = 1'b0;
      repeat (L + 1) tick();
      check($sformatf("vec%0d_fail_inc", k), 64'(fail_cnt - f0), 64'(tbl[k].mis));
      check($sformatf("vec%0d_pass_inc", k), 64'(pass_cnt - p0), 64'(!tbl[k].mis));
      check($sformatf("vec%0d_err_valid", k), 64'(bus.err_valid), 64'(tbl[k].mis));
      check($sformatf("vec%0d_rec_low", k), 64'(bus.err_data[27:0]),
            tbl[k].mis ? 64'({tbl[k].o, tbl[k].oe, tbl[k].low}) : 64'd0);
      tick();
    end
    bus.leds = '0; bus.leds_ex = '0;

    // FIFO overflow: ten failures with no reader, then push and pop on the same edge.
    clear_tick();
    bus.err_ready = 1'b0;
    bus.out = 6'd1; bus.out_ex = 6'd2;
    bus.sample_valid = 1'b1;
    repeat (10) tick();
    bus.sample_valid = 1'b0;
    repeat (4) tick();
    check("t4_fail", 64'(fail_cnt), 64'd10);
    check("t4_drop", 64'(drop_cnt), 64'd2);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (2) tick();
    bus.err_ready = 1'b1;
    tick();
    check("t4_fail_full_pop", 64'(fail_cnt), 64'd11);
    check("t4_no_drop_full_pop", 64'(drop_cnt), 64'd2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.err_valid) n++;
      tick();
    end
    check("t4_occupancy", 64'(n), 64'd8);

    // Clear with four records queued and three samples in flight.
    clear_tick();
    bus.err_ready = 1'b0;
    bus.sample_valid = 1'b1;
    repeat (4) tick();
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    check("t5_pre_fail", 64'(fail_cnt), 64'd4);
    bus.sample_valid = 1'b1;
    repeat (3) tick();
    bus.sample_valid = 1'b0;
    clear_tick();
    check("t5_fail_zero", 64'(fail_cnt), 64'd0);
    check("t5_err_valid_zero", 64'(bus.err_valid), 64'd0);
    repeat (4) tick();
    check("t5_no_late_fail", 64'(fail_cnt), 64'd0);
    check("t5_no_late_pass", 64'(pass_cnt), 64'd0);

    // Asynchronous reset in the middle of a failing burst.
    bus.sample_valid = 1'b1;
    repeat (5) tick();
    bus.sample_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_async_fail", 64'(fail_cnt), 64'd0);
    check("t6_async_valid", 64'(bus.err_valid), 64'd0);
    check("t6_async_data", 64'(bus.err_data), 64'd0);
    model_reset();
    tick();
    rst = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    check("t6_fail_after", 64'(fail_cnt), 64'd1);
    check("t6_stamp_restart", 64'(bus.err_data[43:28]), 64'd2);

    // Random traffic with periodic reader stalls and occasional clears.
    clear_tick();
    for (int i = 0; i < 3000; i++) begin
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.out          = 6'($urandom);
      bus.out_ex       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : bus.out;
      bus.leds         = 16'($urandom);
      bus.leds_ex      = ($urandom_range(0, 4) == 0) ? (bus.leds ^ (16'(1) << $urandom_range(0, 15))) : bus.leds;
      bus.err_ready    = (((i / 150) % 3) == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      clear            = ($urandom_range(0, 399) == 0);
      tick();
    end
    clear = 1'b0;
    bus.sample_valid = 1'b0;
    bus.err_ready = 1'b1;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alsu_result_checker.md
# alsu_result_checker

Result-side companion to the ALSU stimulus interface. It consumes the DUT outputs (`out`, `leds`) and the golden-model outputs (`out_ex`, `leds_ex`) and aligns them to the cycle on which stimulus was applied. It counts passes and fails, and buffers every failing sample in a small FIFO drained by a valid/ready reader. It sits in the testbench top beside the DUT and golden model, and is synthesizable so it can also run on an emulator.

## Interface
- `LATENCY`, 2, cycles from `sample_valid` to the cycle on which outputs are compared; legal range 1..8.
- `FIFO_DEPTH`, 8, failure-record entries; power of two, 2..64.
- `CNT_W`, 16, width of pass/fail/drop counters.

- `clk`  in  1  sampling clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous clear of counters, FIFO, delay line and timestamp.
- `sample_valid`  in  1  stimulus applied to the DUT this cycle.
- `out`  in  6  DUT result (signed).
- `out_ex`  in  6  expected result (signed).
- `leds`  in  16  DUT LED vector.
- `leds_ex`  in  16  expected LED vector.
- `err_valid`  out  1  failure record available.
- `err_ready`  in  1  reader accepts the record.
- `err_data`  out  44  record `{stamp[15:0], out[5:0], out_ex[5:0], leds^leds_ex[15:0]}`.
- `pass_cnt`  out  CNT_W  compared samples that matched.
- `fail_cnt`  out  CNT_W  compared samples that mismatched.
- `drop_cnt`  out  CNT_W  failures lost because the FIFO was full.

## Operation
- Delay line: a `LATENCY`-stage shift register of `sample_valid`. Its last stage (`cmp_en`) marks the compare cycle.
- Timestamp: a free-running 16-bit `stamp`, +1 every cycle, wraps 0xFFFF→0. The record carries the `stamp` of the compare cycle.
- On `cmp_en`:
  - A mismatch is `out != out_ex`, OR'd with `leds != leds_ex` when LED checking is compiled in.
  - Match: `pass_cnt`+1.
  - Mismatch: `fail_cnt`+1, and a record is pushed. If the FIFO is full and not popped that cycle, the record is discarded and `drop_cnt`+1.
- All counters saturate at all-ones; they never wrap.
- FIFO is first-word-fall-through. `err_data` is valid whenever `err_valid`=1 and holds stable until popped. A pop occurs when `err_valid && err_ready`.
- Push and pop in the same cycle:
  - FIFO full: both succeed, occupancy unchanged, no drop.
  - FIFO empty: no bypass; the record appears the next cycle.
- Reader handshake: `err_ready` may be asserted without `err_valid`. `err_valid` must not drop until popped.
- `clear`=1 in cycle t takes effect at the clock edge ending t: counters, `stamp`, delay line and FIFO are all zeroed, and samples in flight are discarded. `clear` has priority over a compare in the same cycle.

## Timing
- Reset values, held while `rst`=0: `err_valid`=0, `err_data`=0, `pass_cnt`=`fail_cnt`=`drop_cnt`=0. Delay line, `stamp` and FIFO pointers are also 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). Records not yet read are lost.
- `sample_valid` at edge t → compare at edge t+`LATENCY` → counter updated and `err_valid` visible after edge t+`LATENCY`+1.
- Back-to-back `sample_valid` gives one compare per cycle; no bubbles.
- Throughput: one push and one pop per cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `ALSU_CHK_LEDS_EN` defined:
  - `leds` is compared against `leds_ex`, and a LED-only mismatch counts as a failure.
  - The record's low 16 bits carry `leds^leds_ex`.
- `ALSU_CHK_LEDS_EN` undefined:
  - Only `out` is compared; the LED ports are ignored.
  - The record's low 16 bits are 0.

## Test plan
- Reset, then 10 `sample_valid` with `out`=`out_ex`=5 → `pass_cnt`=10, `fail_cnt`=0, `err_valid` never asserted.
- Single mismatch `out`=3, `out_ex`=-3 at compare cycle, `stamp`=0x0012 → `fail_cnt`=1, `err_data`={0x0012, 6'o03, 6'o75, 0x0000}, `err_valid` rises one cycle after compare.
- `ALSU_CHK_LEDS_EN` defined, `leds`=0x00F0, `leds_ex`=0x00FF, `out` equal → record low bits 0x000F. Same stimulus with the macro undefined → `pass_cnt`+1, no record.
- `err_ready`=0, 10 consecutive failures, `FIFO_DEPTH`=8 → 8 records held, `drop_cnt`=2. Then a failure with FIFO full and `err_ready`=1 in the same cycle → no drop, occupancy stays 8.
- `clear` pulse while 3 samples are in flight and the FIFO holds 4 records → next cycle all counters 0, `err_valid`=0, and the in-flight samples produce no compares.
- `rst` deasserted low for one cycle mid-burst → outputs zero immediately; after release `stamp` restarts at 0 and counting resumes normally.
